// File: rtl/cpu_top.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_top
//  Description : 16-bit accumulator CPU, multi-cycle and microprogrammed.
//                It reaches one external 256x16 synchronous memory through
//                the MAR (address) and MBR (data) registers. Each memory read
//                has one wait state. A store is flagged by Control_Signals[11]
//                for a single cycle, and the memory model samples that bit
//                hierarchically.
//  Ports       : clk            - system clock, rising edge
//                rst            - synchronous active-high reset
//                MBR_in_memory  - registered read data from memory
//                MAR_out_memory - memory address (MAR register)
//                MBR_out_memory - memory write data (MBR register)
//  Options     : CPU_MPY_EN     - when defined, builds the signed 16x16
//                                 multiplier for MPY. When undefined, MPY
//                                 executes as a 7-clock NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_top #(
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter int         ADDR_W   = 8,
    parameter int         DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] MBR_in_memory,
    output logic [ADDR_W-1:0] MAR_out_memory,
    output logic [DATA_W-1:0] MBR_out_memory
);

    localparam logic [7:0] c_OP_STORE  = 8'h01;
    localparam logic [7:0] c_OP_LOAD   = 8'h02;
    localparam logic [7:0] c_OP_ADD    = 8'h03;
    localparam logic [7:0] c_OP_SUB    = 8'h04;
    localparam logic [7:0] c_OP_JMPGEZ = 8'h05;
    localparam logic [7:0] c_OP_JMP    = 8'h06;
    localparam logic [7:0] c_OP_HALT   = 8'h07;
    localparam logic [7:0] c_OP_MPY    = 8'h08;
    localparam logic [7:0] c_OP_AND    = 8'h0A;
    localparam logic [7:0] c_OP_OR     = 8'h0B;
    localparam logic [7:0] c_OP_NOT    = 8'h0C;
    localparam logic [7:0] c_OP_SHIFTR = 8'h0D;
    localparam logic [7:0] c_OP_SHIFTL = 8'h0E;

    typedef enum logic [3:0] {
        ST_F0   = 4'd0,
        ST_F1   = 4'd1,
        ST_F2   = 4'd2,
        ST_D    = 4'd3,
        ST_O0   = 4'd4,
        ST_O1   = 4'd5,
        ST_EX   = 4'd6,
        ST_AC   = 4'd7,
        ST_S0   = 4'd8,
        ST_S1   = 4'd9,
        ST_JP   = 4'd10,
        ST_HALT = 4'd11
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [7:0]  r_mar;
    logic [15:0] r_mbr;
    logic [7:0]  r_ir;
    logic [15:0] r_acc;
    logic [15:0] r_mr;

    logic [15:0] Control_Signals;
    logic [7:0]  w_opcode;
    logic        w_unused;

    assign MAR_out_memory = r_mar;
    assign MBR_out_memory = r_mbr;

    // While in D, the opcode is still in MBR and has not yet reached IR.
    assign w_opcode = r_mbr[15:8];

`ifdef CPU_MPY_EN
    logic signed [31:0] w_product;
    assign w_product = $signed(r_acc) * $signed(r_mbr);
`endif

    // Micro-control decode. F0 decodes to all zeros, so the reset state
    // shows a zero control word. Bit 11 is the memory write strobe. The
    // other bits tag micro-operations so they are visible during debug.
    always_comb begin
        Control_Signals = 16'h0000;
        case (r_state)
            ST_F1, ST_O0: Control_Signals[0]  = 1'b1;  // read wait state
            ST_F2: begin
                Control_Signals[1] = 1'b1;             // MBR <- memory
                Control_Signals[2] = 1'b1;             // PC increment
            end
            ST_D: begin
                Control_Signals[3] = 1'b1;             // IR load
                Control_Signals[4] = 1'b1;             // MAR <- operand address
            end
            ST_O1:   Control_Signals[1]  = 1'b1;
            ST_EX:   Control_Signals[5]  = 1'b1;       // memory-operand ALU op
            ST_AC:   Control_Signals[6]  = 1'b1;       // accumulator-only op
            ST_S0:   Control_Signals[7]  = 1'b1;       // MBR <- ACC
            ST_S1:   Control_Signals[11] = 1'b1;       // memory write strobe
            ST_JP:   Control_Signals[8]  = 1'b1;       // conditional PC load
            ST_HALT: Control_Signals[9]  = 1'b1;
            default: Control_Signals = 16'h0000;
        endcase
    end

    // Logic inside the core never reads the control word or MR. Only the
    // memory model and debug observe them.
    assign w_unused = ^{Control_Signals, r_mr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_F0;
            r_pc    <= RESET_PC;
            r_mar   <= 8'h00;
            r_mbr   <= 16'h0000;
            r_ir    <= 8'h00;
            r_acc   <= 16'h0000;
            r_mr    <= 16'h0000;
        end else begin
            case (r_state)
                ST_F0: begin
                    r_mar   <= r_pc;
                    r_state <= ST_F1;
                end
                ST_F1: r_state <= ST_F2;
                ST_F2: begin
                    r_mbr   <= MBR_in_memory;
                    r_pc    <= r_pc + 8'd1;            // wraps 255 -> 0
                    r_state <= ST_D;
                end
                ST_D: begin
                    r_ir  <= w_opcode;
                    r_mar <= r_mbr[7:0];
                    case (w_opcode)
                        c_OP_HALT:                         r_state <= ST_HALT;
                        c_OP_JMP, c_OP_JMPGEZ:             r_state <= ST_JP;
                        c_OP_STORE:                        r_state <= ST_S0;
                        c_OP_NOT, c_OP_SHIFTR, c_OP_SHIFTL: r_state <= ST_AC;
                        // Memory-operand ops and unknown opcodes both fetch
                        // an operand, so NOPs take the full 7 clocks.
                        default:                           r_state <= ST_O0;
                    endcase
                end
                ST_O0: r_state <= ST_O1;
                ST_O1: begin
                    r_mbr   <= MBR_in_memory;
                    r_state <= ST_EX;
                end
                ST_EX: begin
                    case (r_ir)
                        c_OP_LOAD: r_acc <= r_mbr;
                        c_OP_ADD:  r_acc <= r_acc + r_mbr;
                        c_OP_SUB:  r_acc <= r_acc - r_mbr;
                        c_OP_AND:  r_acc <= r_acc & r_mbr;
                        c_OP_OR:   r_acc <= r_acc | r_mbr;
                        c_OP_MPY: begin
`ifdef CPU_MPY_EN
                            r_acc <= w_product[15:0];
                            r_mr  <= w_product[31:16];
`else
                            // No multiplier is built. The operand is fetched
                            // and then discarded.
                            r_acc <= r_acc;
`endif
                        end
                        default: r_acc <= r_acc;
                    endcase
                    r_state <= ST_F0;
                end
                ST_AC: begin
                    case (r_ir)
                        c_OP_NOT:    r_acc <= ~r_acc;
                        c_OP_SHIFTR: r_acc <= {r_acc[15], r_acc[15:1]};
                        c_OP_SHIFTL: r_acc <= {r_acc[14:0], 1'b0};
                        default:     r_acc <= r_acc;
                    endcase
                    r_state <= ST_F0;
                end
                ST_S0: begin
                    r_mbr   <= r_acc;
                    r_state <= ST_S1;
                end
                // The memory commits MBR at MAR on the edge that closes S1.
                ST_S1: r_state <= ST_F0;
                ST_JP: begin
                    if (r_ir == c_OP_JMP || (r_ir == c_OP_JMPGEZ && !r_acc[15])) begin
                        r_pc <= r_mar;
                    end
                    r_state <= ST_F0;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_F0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_top
//  Description : Self-checking bench for cpu_top. It contains a 256x16
//                synchronous memory model and a table of single-instruction
//                vectors, plus hand-written multi-cycle programs: store/halt,
//                a summing loop with multiply, branch conditions and reset
//                during a store.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_top;

`ifdef CPU_MPY_EN
    localparam bit c_MPY_ON = 1'b1;
`else
    localparam bit c_MPY_ON = 1'b0;
`endif
    localparam logic [3:0] c_HALT_ENC = 4'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rd_data = 16'h0000;
    logic [7:0]  MAR_out;
    logic [15:0] MBR_out;

    logic [15:0] mem [256];
    int          wr_count = 0;
    logic [7:0]  wr_addr_log [64];
    logic [15:0] wr_data_log [64];

    int n_checks = 0;
    int n_errors = 0;

    cpu_top dut (
        .clk            (clk),
        .rst            (rst),
        .MBR_in_memory  (rd_data),
        .MAR_out_memory (MAR_out),
        .MBR_out_memory (MBR_out)
    );

    always #5 clk = ~clk;

    // Synchronous memory. Read data is registered, and writes follow the
    // strobe. Address 255 is never written.
    always @(posedge clk) begin
        rd_data <= mem[MAR_out];
        if (dut.Control_Signals[11]) begin
            if (MAR_out != 8'hFF) mem[MAR_out] <= MBR_out;
            wr_addr_log[wr_count % 64] <= MAR_out;
            wr_data_log[wr_count % 64] <= MBR_out;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: hold reset, clear memory; caller then loads program.
    task automatic begin_prog();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget, output int cycles);
        cycles = 0;
        while (4'(dut.r_state) != c_HALT_ENC && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (4'(dut.r_state) != c_HALT_ENC) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s halt-timeout: got %0d cycles expected halt", name, cycles);
        end
    endtask

    typedef struct {
        logic [15:0] acc0;
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [15:0] exp_acc;
        logic [15:0] exp_mr;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int cyc;
        int w0;
        logic [15:0] acc_set [3];
        logic [7:0]  pc_exp [3];

        // Cycle count from reset release to HALT entry is
        // LOAD (7) + op (7 for memory ops, 5 for unary ops) + 4 for the HALT fetch.
        vecs[0]  = '{16'h1234, 8'h02, 16'h00AA, 16'h00AA, 16'h0000, 18};
        vecs[1]  = '{16'h7FFF, 8'h03, 16'h0001, 16'h8000, 16'h0000, 18};
        vecs[2]  = '{16'hFFFF, 8'h03, 16'h0002, 16'h0001, 16'h0000, 18};
        vecs[3]  = '{16'h0000, 8'h04, 16'h0001, 16'hFFFF, 16'h0000, 18};
        vecs[4]  = '{16'hF0F0, 8'h0A, 16'h3C3C, 16'h3030, 16'h0000, 18};
        vecs[5]  = '{16'hF0F0, 8'h0B, 16'h0F01, 16'hFFF1, 16'h0000, 18};
        vecs[6]  = '{16'h00FF, 8'h0C, 16'h1111, 16'hFF00, 16'h0000, 16};
        vecs[7]  = '{16'h8002, 8'h0D, 16'h1111, 16'hC001, 16'h0000, 16};
        vecs[8]  = '{16'h0003, 8'h0D, 16'h1111, 16'h0001, 16'h0000, 16};
        vecs[9]  = '{16'h8001, 8'h0E, 16'h1111, 16'h0002, 16'h0000, 16};
        vecs[10] = '{16'h5555, 8'hFF, 16'h1234, 16'h5555, 16'h0000, 18};
        vecs[11] = '{16'h5555, 8'h09, 16'h1234, 16'h5555, 16'h0000, 18};
        vecs[12] = '{16'h7FFF, 8'h08, 16'h0002,
                     c_MPY_ON ? 16'hFFFE : 16'h7FFF, 16'h0000, 18};
        vecs[13] = '{16'hFFF4, 8'h08, 16'h006E,
                     c_MPY_ON ? 16'hFAD8 : 16'hFFF4,
                     c_MPY_ON ? 16'hFFFF : 16'h0000, 18};

        // ---------------- Reset state ----------------
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset MAR", 32'(MAR_out), 32'h0);
        chk("reset MBR", 32'(MBR_out), 32'h0);
        chk("reset PC", 32'(dut.r_pc), 32'h0);
        chk("reset ACC", 32'(dut.r_acc), 32'h0);
        chk("reset MR", 32'(dut.r_mr), 32'h0);
        chk("reset ctrl", 32'(dut.Control_Signals), 32'h0);

        // ---------------- Table of single-instruction vectors ----------------
        for (int v = 0; v < 14; v++) begin
            begin_prog();
            mem[0]  <= 16'h0232;
            mem[1]  <= {vecs[v].op, 8'd51};
            mem[2]  <= 16'h0700;
            mem[50] <= vecs[v].acc0;
            mem[51] <= vecs[v].opnd;
            release_reset();
            run_to_halt($sformatf("vec%0d", v), 200, cyc);
            chk($sformatf("vec%0d acc", v), 32'(dut.r_acc), 32'(vecs[v].exp_acc));
            chk($sformatf("vec%0d mr", v), 32'(dut.r_mr), 32'(vecs[v].exp_mr));
            chk($sformatf("vec%0d cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
            chk($sformatf("vec%0d pc", v), 32'(dut.r_pc), 32'h3);
        end

        // ---------------- LOAD 50 / STORE 60 / HALT ----------------
        begin_prog();
        mem[0] <= 16'h0232; mem[1] <= 16'h013C; mem[2] <= 16'h0700; mem[50] <= 16'h00AA;
        w0 = wr_count;
        release_reset();
        run_to_halt("store1", 200, cyc);
        chk("store1 count", 32'(wr_count - w0), 32'h1);
        chk("store1 addr", 32'(wr_addr_log[w0 % 64]), 32'd60);
        chk("store1 data", 32'(wr_data_log[w0 % 64]), 32'h00AA);
        chk("store1 cycles", 32'(cyc), 32'd17);
        repeat (100) @(posedge clk);
        #1;
        chk("halt idle writes", 32'(wr_count - w0), 32'h1);
        chk("halt idle state", 32'(dut.r_state), 32'(c_HALT_ENC));
        chk("halt idle mem60", 32'(mem[60]), 32'h00AA);

        // ---------------- Summing loop, then MPY / SHIFTL / AND ----------------
        begin_prog();
        mem[0]  <= 16'h022A; mem[1]  <= 16'h032B; mem[2]  <= 16'h012A;
        mem[3]  <= 16'h022B; mem[4]  <= 16'h0328; mem[5]  <= 16'h012B;
        mem[6]  <= 16'h0429; mem[7]  <= 16'h0509; mem[8]  <= 16'h0600;
        mem[9]  <= 16'h022A; mem[10] <= 16'h013C; mem[11] <= 16'h082C;
        mem[12] <= 16'h013D; mem[13] <= 16'h0E00; mem[14] <= 16'h013E;
        mem[15] <= 16'h0A2D; mem[16] <= 16'h013F; mem[17] <= 16'h0700;
        mem[40] <= 16'd2;    mem[41] <= 16'd22;   mem[42] <= 16'd0;
        mem[43] <= 16'd2;    mem[44] <= 16'hFFF4; mem[45] <= 16'h0334;
        release_reset();
        run_to_halt("loop", 5000, cyc);
        chk("loop sum", 32'(mem[60]), 32'h006E);
        chk("full mpy", 32'(mem[61]), c_MPY_ON ? 32'hFAD8 : 32'h006E);
        chk("full shl", 32'(mem[62]), c_MPY_ON ? 32'hF5B0 : 32'h00DC);
        chk("full and", 32'(mem[63]), c_MPY_ON ? 32'h0130 : 32'h0014);

        // ---------------- JMPGEZ taken / not taken ----------------
        acc_set[0] = 16'h8000; pc_exp[0] = 8'd3;
        acc_set[1] = 16'h0000; pc_exp[1] = 8'd6;
        acc_set[2] = 16'h7FFF; pc_exp[2] = 8'd6;
        for (int k = 0; k < 3; k++) begin
            begin_prog();
            mem[0] <= 16'h0232; mem[1] <= 16'h0505; mem[2] <= 16'h0700;
            mem[5] <= 16'h0700; mem[50] <= acc_set[k];
            release_reset();
            run_to_halt($sformatf("jmpgez%0d", k), 200, cyc);
            chk($sformatf("jmpgez%0d pc", k), 32'(dut.r_pc), 32'(pc_exp[k]));
        end

        // ---------------- Reset asserted during S1 of a STORE ----------------
        begin_prog();
        mem[0] <= 16'h0232; mem[1] <= 16'h013C; mem[2] <= 16'h0700; mem[50] <= 16'h1234;
        release_reset();
        cyc = 0;
        while (!dut.Control_Signals[11] && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rstS1 strobe seen", 32'(dut.Control_Signals[11]), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        w0 = wr_count;
        chk("rstS1 pc", 32'(dut.r_pc), 32'h0);
        chk("rstS1 acc", 32'(dut.r_acc), 32'h0);
        chk("rstS1 mbr", 32'(MBR_out), 32'h0);
        chk("rstS1 ctrl", 32'(dut.Control_Signals), 32'h0);
        mem[0] <= 16'h0700;
        @(negedge clk);
        rst = 1'b0;
        run_to_halt("rstS1", 200, cyc);
        chk("rstS1 no write", 32'(wr_count - w0), 32'h0);
        chk("rstS1 refetch pc", 32'(dut.r_pc), 32'h1);
        chk("rstS1 acc after", 32'(dut.r_acc), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
